// File: rtl/dong_ho_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dong_ho_pkg
// Brief    : Shared types, BCD limits and set_field encodings for dong_ho_hms
// Revision : 1.0 - initial release
// ============================================================================
package dong_ho_pkg;

  // Mode state machine encoding. SET_AH/SET_AM only reachable in alarm builds.
  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_HH = 3'd1,
    ST_SET_MM = 3'd2,
    ST_SET_AH = 3'd3,
    ST_SET_AM = 3'd4
  } state_e;

  localparam logic [7:0] BCD_MAX_SEC  = 8'h59;
  localparam logic [7:0] BCD_MAX_MIN  = 8'h59;
  localparam logic [7:0] BCD_MAX_HOUR = 8'h23;

  localparam logic [1:0] FIELD_NONE  = 2'd0;
  localparam logic [1:0] FIELD_HOUR  = 2'd1;
  localparam logic [1:0] FIELD_MIN   = 2'd2;
  localparam logic [1:0] FIELD_ALARM = 2'd3;

  // Two-digit BCD increment without wrap; units 9 rolls into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else                r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage : dong_ho_pkg
`default_nettype wire

// File: rtl/dong_ho_hms_bcd_mod_cnt.sv
`default_nettype none
// ============================================================================
// Module   : bcd_mod_cnt
// Brief    : Two-digit BCD modulo counter (0..MAX) with clear and carry-out
// Revision : 1.0 - initial release
// ============================================================================
module bcd_mod_cnt
  import dong_ho_pkg::*;
#(
  parameter logic [7:0] MAX      = 8'h59,
  parameter logic [7:0] LOAD_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [7:0] value_o,
  output logic       carry_o
);

  logic [7:0] value_q;
  logic [7:0] value_d;

  // Next value: clear dominates, wrap to 00 after MAX.
  always_comb begin
    value_d = value_q;
    if (clr_i)                value_d = 8'h00;
    else if (inc_i) begin
      if (value_q == MAX)     value_d = 8'h00;
      else                    value_d = bcd_inc(value_q);
    end
  end

  // Counter register, loaded with LOAD_VAL on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= LOAD_VAL;
    else        value_q <= value_d;
  end

  assign value_o = value_q;
  assign carry_o = inc_i && (value_q == MAX);

endmodule : bcd_mod_cnt
`default_nettype wire

// File: rtl/dong_ho_hms.sv
`default_nettype none
// ============================================================================
// Module   : dong_ho_hms
// Brief    : 24-hour BCD time-of-day core with hour/minute setting.
//            Optional alarm (registers ah/am, output alarm) enabled by
//            defining DH_ALARM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dong_ho_hms
  import dong_ho_pkg::*;
#(
  parameter logic [7:0] HH_RST = 8'h00,
  parameter logic [7:0] MM_RST = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] set_field,
`ifdef DH_ALARM_EN
  output logic       alarm,
`endif
  output logic       day_pulse
);

  logic   hist_1hz_q, hist_mode_q, hist_inc_q;
  logic   sec_stb, mode_stb, inc_raw_stb, inc_stb;
  state_e state_q, state_d;
  logic   time_run, leaving_run;
  logic   ss_inc, ss_clr, mm_inc, hh_inc;
  logic   ss_carry, mm_carry, hh_carry;
  logic   day_pulse_q;

  // Edge-detect history; reset high so a level already high at release is not a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_1hz_q  <= 1'b1;
      hist_mode_q <= 1'b1;
      hist_inc_q  <= 1'b1;
    end else begin
      hist_1hz_q  <= clk_1hz;
      hist_mode_q <= btn_mode;
      hist_inc_q  <= btn_inc;
    end
  end

  assign sec_stb     = clk_1hz  & ~hist_1hz_q;
  assign mode_stb    = btn_mode & ~hist_mode_q;
  assign inc_raw_stb = btn_inc  & ~hist_inc_q;
  // A mode change in the same cycle swallows the increment.
  assign inc_stb     = inc_raw_stb & ~mode_stb;

  // Mode state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // Mode sequencing on each btn_mode strobe.
  always_comb begin
    state_d = state_q;
    if (mode_stb) begin
      case (state_q)
        ST_RUN:    state_d = ST_SET_HH;
        ST_SET_HH: state_d = ST_SET_MM;
`ifdef DH_ALARM_EN
        ST_SET_MM: state_d = ST_SET_AH;
        ST_SET_AH: state_d = ST_SET_AM;
`endif
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // Time keeps counting everywhere except while hours/minutes are edited.
  assign time_run    = (state_q != ST_SET_HH) && (state_q != ST_SET_MM);
  assign leaving_run = (state_q == ST_RUN) && mode_stb;
  assign ss_clr      = !time_run || leaving_run;
  assign ss_inc      = sec_stb && time_run && !leaving_run;
  assign mm_inc      = (time_run && ss_carry) || ((state_q == ST_SET_MM) && inc_stb);
  assign hh_inc      = (time_run && mm_carry) || ((state_q == ST_SET_HH) && inc_stb);

  bcd_mod_cnt #(.MAX(BCD_MAX_SEC), .LOAD_VAL(8'h00)) u_ss (
    .clk(clk), .rst_n(rst_n), .inc_i(ss_inc), .clr_i(ss_clr),
    .value_o(ss), .carry_o(ss_carry)
  );

  bcd_mod_cnt #(.MAX(BCD_MAX_MIN), .LOAD_VAL(MM_RST)) u_mm (
    .clk(clk), .rst_n(rst_n), .inc_i(mm_inc), .clr_i(1'b0),
    .value_o(mm), .carry_o(mm_carry)
  );

  bcd_mod_cnt #(.MAX(BCD_MAX_HOUR), .LOAD_VAL(HH_RST)) u_hh (
    .clk(clk), .rst_n(rst_n), .inc_i(hh_inc), .clr_i(1'b0),
    .value_o(hh), .carry_o(hh_carry)
  );

  // Day pulse registered alongside the 23->00 hour wrap; manual hour edits excluded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) day_pulse_q <= 1'b0;
    else        day_pulse_q <= hh_carry && time_run;
  end

  assign day_pulse = day_pulse_q;

  // Field indicator decoded from the state register only.
  always_comb begin
    set_field = FIELD_NONE;
    case (state_q)
      ST_SET_HH: set_field = FIELD_HOUR;
      ST_SET_MM: set_field = FIELD_MIN;
`ifdef DH_ALARM_EN
      ST_SET_AH: set_field = FIELD_ALARM;
      ST_SET_AM: set_field = FIELD_ALARM;
`endif
      default:   set_field = FIELD_NONE;
    endcase
  end

`ifdef DH_ALARM_EN
  logic [7:0] ah, am;
  logic       ah_carry, am_carry;
  logic       match, match_q, alarm_q, alarm_d;

  bcd_mod_cnt #(.MAX(BCD_MAX_HOUR), .LOAD_VAL(8'h06)) u_ah (
    .clk(clk), .rst_n(rst_n), .inc_i((state_q == ST_SET_AH) && inc_stb), .clr_i(1'b0),
    .value_o(ah), .carry_o(ah_carry)
  );

  bcd_mod_cnt #(.MAX(BCD_MAX_MIN), .LOAD_VAL(8'h00)) u_am (
    .clk(clk), .rst_n(rst_n), .inc_i((state_q == ST_SET_AM) && inc_stb), .clr_i(1'b0),
    .value_o(am), .carry_o(am_carry)
  );

  // Alarm fires on arrival at hh:mm:00 and must not re-arm while that time persists.
  assign match = (state_q == ST_RUN) && (hh == ah) && (mm == am) && (ss == 8'h00);

  // Alarm set/clear: any button strobe or minute change clears, arrival sets.
  always_comb begin
    alarm_d = alarm_q;
    if (mode_stb || inc_raw_stb || mm_inc) alarm_d = 1'b0;
    else if (match && !match_q)            alarm_d = 1'b1;
  end

  // Alarm registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      match_q <= match;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;
`endif

endmodule : dong_ho_hms
`default_nettype wire
